// File: rtl/imem_sync_pkg.sv
// Shared definitions for the instruction memory: fault codes and FSM states.
// Optional feature macro used by the design: IMEM_PARITY_EN (per-word even parity).
package imem_sync_pkg;

    localparam logic [1:0] FAULT_OK       = 2'b00;
    localparam logic [1:0] FAULT_MISALIGN = 2'b01;
    localparam logic [1:0] FAULT_OOR      = 2'b10;
    localparam logic [1:0] FAULT_PARITY   = 2'b11;

    typedef enum logic [0:0] {
        ST_CLEAR = 1'b0,
        ST_READY = 1'b1
    } state_t;

endpackage

// File: rtl/imem_ram.sv
// imem_ram: word storage for imem_sync. One write access and one synchronous
// read access per cycle on a single clock. A read of the word being written in
// the same cycle returns the new data (write-first).
// Ports:
//   clk          rising-edge clock
//   we/waddr/wdata   write strobe, word index, word (data plus optional parity)
//   re/raddr     read enable and word index; rdata updates only when re=1
//   rdata        registered read data, holds between reads
module imem_ram #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 256,
    parameter int IDX_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [IDX_W-1:0] waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic             re,
    input  logic [IDX_W-1:0] raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [WIDTH-1:0] r_rdata;

    always_ff @(posedge clk) begin
        if (we) begin
            r_mem[waddr] <= wdata;
        end
        if (re) begin
            r_rdata <= (we && (waddr == raddr)) ? wdata : r_mem[raddr];
        end
    end

    assign rdata = r_rdata;

endmodule

// File: rtl/imem_sync.sv
// imem_sync: instruction memory with a one-cycle fetch port and a program-load
// write port. After reset the whole array is zeroed, one word per cycle, before
// fetches are accepted.
// Ports:
//   clk, rst_n                 clock, synchronous active-low reset
//   fetch_req/fetch_addr       fetch request and byte address
//   fetch_stall                freeze the current response
//   fetch_ready                high when requests can be accepted
//   fetch_valid/instr/fault    response (one cycle after acceptance)
//   prog_we/prog_addr/prog_data   program-load write
// Build option: define IMEM_PARITY_EN to store an even-parity bit per word and
// report FAULT_PARITY on a mismatching read.
//
// state | meaning
// CLEAR | zeroing memory, one word per cycle; fetches and writes blocked
// READY | serving fetches and program-load writes
module imem_sync
    import imem_sync_pkg::*;
#(
    parameter int                DATA_W    = 32,
    parameter int                DEPTH     = 256,
    parameter int                ADDR_W    = 32,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              fetch_req,
    input  logic [ADDR_W-1:0] fetch_addr,
    input  logic              fetch_stall,
    output logic              fetch_ready,
    output logic              fetch_valid,
    output logic [DATA_W-1:0] fetch_instr,
    output logic [1:0]        fetch_fault,
    input  logic              prog_we,
    input  logic [ADDR_W-1:0] prog_addr,
    input  logic [DATA_W-1:0] prog_data
);

    localparam int IDX_W = $clog2(DEPTH);
`ifdef IMEM_PARITY_EN
    localparam int PAR_W = 1;
`else
    localparam int PAR_W = 0;
`endif
    localparam int MEM_W = DATA_W + PAR_W;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [IDX_W-1:0]  r_clr_idx;
    logic              r_valid;
    logic              r_rd_ok;
    logic [1:0]        r_fault;

    logic              w_clearing;
    logic              w_ready;
    logic              w_accept;
    logic [ADDR_W:0]   w_fetch_diff;
    logic [ADDR_W:0]   w_prog_diff;
    logic [1:0]        w_fetch_fault;
    logic [1:0]        w_prog_fault;
    logic              w_ram_we;
    logic [IDX_W-1:0]  w_ram_waddr;
    logic [MEM_W-1:0]  w_ram_wdata;
    logic              w_ram_re;
    logic [MEM_W-1:0]  w_ram_rdata;

    // diff carries a borrow bit in its MSB: set when the address is below BASE_ADDR.
    function automatic logic [1:0] addr_fault(input logic [ADDR_W:0] diff,
                                              input logic [1:0]      lsb);
        if (lsb != 2'b00) begin
            return FAULT_MISALIGN;
        end
        if (diff[ADDR_W] || ((diff[ADDR_W-1:0] >> 2) >= ADDR_W'(DEPTH))) begin
            return FAULT_OOR;
        end
        return FAULT_OK;
    endfunction

    assign w_fetch_diff  = {1'b0, fetch_addr} - {1'b0, BASE_ADDR};
    assign w_prog_diff   = {1'b0, prog_addr}  - {1'b0, BASE_ADDR};
    assign w_fetch_fault = addr_fault(w_fetch_diff, fetch_addr[1:0]);
    assign w_prog_fault  = addr_fault(w_prog_diff,  prog_addr[1:0]);

    // FSM: state register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_CLEAR;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM: next state
    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            ST_CLEAR: if (r_clr_idx == IDX_W'(DEPTH - 1)) w_state_nxt = ST_READY;
            ST_READY: w_state_nxt = ST_READY;
            default:  w_state_nxt = ST_CLEAR;
        endcase
    end

    // FSM: outputs
    always_comb begin
        w_clearing = (r_state == ST_CLEAR);
        w_ready    = (r_state == ST_READY);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_clr_idx <= '0;
        end else if (w_clearing) begin
            r_clr_idx <= r_clr_idx + 1'b1;
        end
    end

    assign w_accept = w_ready && fetch_req && !fetch_stall;

    // Write port is owned by the clear sequence while clearing.
    always_comb begin
        w_ram_we    = 1'b0;
        w_ram_waddr = r_clr_idx;
        w_ram_wdata = '0;
        if (w_clearing) begin
            w_ram_we = 1'b1;
        end else if (prog_we && (w_prog_fault == FAULT_OK)) begin
            w_ram_we    = 1'b1;
            w_ram_waddr = w_prog_diff[IDX_W+1:2];
`ifdef IMEM_PARITY_EN
            w_ram_wdata = {^prog_data, prog_data};
`else
            w_ram_wdata = prog_data;
`endif
        end
    end

    // Faulting fetches never touch the array.
    assign w_ram_re = w_accept && (w_fetch_fault == FAULT_OK);

    imem_ram #(
        .WIDTH (MEM_W),
        .DEPTH (DEPTH),
        .IDX_W (IDX_W)
    ) u_ram (
        .clk   (clk),
        .we    (w_ram_we),
        .waddr (w_ram_waddr),
        .wdata (w_ram_wdata),
        .re    (w_ram_re),
        .raddr (w_fetch_diff[IDX_W+1:2]),
        .rdata (w_ram_rdata)
    );

    // r_rd_ok marks that the held response comes from the array; the array's
    // read register holds between reads, so the response holds without copying it.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
            r_rd_ok <= 1'b0;
            r_fault <= FAULT_OK;
        end else if (!fetch_stall) begin
            r_valid <= w_accept;
            if (w_accept) begin
                r_rd_ok <= (w_fetch_fault == FAULT_OK);
                r_fault <= w_fetch_fault;
            end
        end
    end

    always_comb begin
        fetch_instr = '0;
        fetch_fault = r_fault;
        if (r_rd_ok) begin
`ifdef IMEM_PARITY_EN
            if (^w_ram_rdata) begin
                fetch_fault = FAULT_PARITY;
            end else begin
                fetch_instr = w_ram_rdata[DATA_W-1:0];
            end
`else
            fetch_instr = w_ram_rdata;
`endif
        end
    end

    assign fetch_ready = w_ready;
    assign fetch_valid = r_valid;

endmodule

// File: tb/tb_imem_sync.sv
module tb_imem_sync;

    localparam int DEPTH = 256;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        fetch_req;
    logic [31:0] fetch_addr;
    logic        fetch_stall;
    logic        fetch_ready;
    logic        fetch_valid;
    logic [31:0] fetch_instr;
    logic [1:0]  fetch_fault;
    logic        prog_we;
    logic [31:0] prog_addr;
    logic [31:0] prog_data;

    always #5 clk = ~clk;

    imem_sync #(
        .DATA_W    (32),
        .DEPTH     (DEPTH),
        .ADDR_W    (32),
        .BASE_ADDR (32'h0)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .fetch_req   (fetch_req),
        .fetch_addr  (fetch_addr),
        .fetch_stall (fetch_stall),
        .fetch_ready (fetch_ready),
        .fetch_valid (fetch_valid),
        .fetch_instr (fetch_instr),
        .fetch_fault (fetch_fault),
        .prog_we     (prog_we),
        .prog_addr   (prog_addr),
        .prog_data   (prog_data)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: plain word array and the response the port should show.
    logic [31:0] m_mem [DEPTH];
    logic        m_valid;
    logic [31:0] m_instr;
    logic [1:0]  m_fault;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [1:0] ref_fault(input logic [31:0] a);
        if (a % 4 != 0) return 2'd1;
        if (a / 4 >= DEPTH) return 2'd2;
        return 2'd0;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < DEPTH; i++) m_mem[i] = 32'h0;
        m_valid = 1'b0;
        m_instr = 32'h0;
        m_fault = 2'd0;
    endtask

    task automatic step(input string tag, input logic req, input logic [31:0] fa,
                        input logic st, input logic we, input logic [31:0] pa,
                        input logic [31:0] pd);
        @(negedge clk);
        fetch_req   = req;
        fetch_addr  = fa;
        fetch_stall = st;
        prog_we     = we;
        prog_addr   = pa;
        prog_data   = pd;
        if (!st) begin
            if (req) begin
                m_valid = 1'b1;
                m_fault = ref_fault(fa);
                if (m_fault != 2'd0)
                    m_instr = 32'h0;
                else if (we && ref_fault(pa) == 2'd0 && (pa / 4) == (fa / 4))
                    m_instr = pd;
                else
                    m_instr = m_mem[fa / 4];
            end else begin
                m_valid = 1'b0;
            end
        end
        if (we && ref_fault(pa) == 2'd0) m_mem[pa / 4] = pd;
        @(posedge clk);
        #1;
        check($sformatf("%s.ready", tag), 32'(fetch_ready), 32'd1);
        check($sformatf("%s.valid", tag), 32'(fetch_valid), 32'(m_valid));
        check($sformatf("%s.instr", tag), fetch_instr, m_instr);
        if (m_valid) check($sformatf("%s.fault", tag), 32'(fetch_fault), 32'(m_fault));
    endtask

    task automatic idle_inputs();
        fetch_req   = 1'b0;
        fetch_addr  = 32'h0;
        fetch_stall = 1'b0;
        prog_we     = 1'b0;
        prog_addr   = 32'h0;
        prog_data   = 32'h0;
    endtask

    // Release reset at a falling edge and count samples with fetch_ready low.
    task automatic release_and_count(input string tag);
        int n;
        @(negedge clk);
        rst_n = 1'b1;
        n = 0;
        while (fetch_ready !== 1'b1 && n < 1000) begin
            n++;
            @(negedge clk);
        end
        check(tag, 32'(n), 32'(DEPTH));
        model_reset();
    endtask

    task automatic hold_reset(input string tag);
        @(negedge clk);
        idle_inputs();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check($sformatf("%s.ready", tag), 32'(fetch_ready), 32'd0);
        check($sformatf("%s.valid", tag), 32'(fetch_valid), 32'd0);
        check($sformatf("%s.instr", tag), fetch_instr, 32'h0);
        check($sformatf("%s.fault", tag), 32'(fetch_fault), 32'd0);
    endtask

    initial begin
        logic [31:0] fa, pa, pd;
        logic        req, st, we;
        int          r;

        idle_inputs();
        rst_n = 1'b0;
        model_reset();

        hold_reset("rst0");
        release_and_count("clear_len0");

        // First fetch after clear reads zero.
        step("fetch0_zero", 1'b1, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
        // Program word 0 then fetch it.
        step("prog0", 1'b0, 32'h0, 1'b0, 1'b1, 32'h0, 32'h20110003);
        step("fetch0", 1'b1, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
        // Faults.
        step("misalign", 1'b1, 32'h6, 1'b0, 1'b0, 32'h0, 32'h0);
        step("oor", 1'b1, 32'h400, 1'b0, 1'b0, 32'h0, 32'h0);
        step("last_word", 1'b1, 32'h3FC, 1'b0, 1'b0, 32'h0, 32'h0);
        // Dropped writes must not land anywhere.
        step("bad_wr_mis", 1'b0, 32'h0, 1'b0, 1'b1, 32'h5, 32'hDEADBEEF);
        step("bad_wr_oor", 1'b0, 32'h0, 1'b0, 1'b1, 32'h404, 32'hDEADBEEF);
        step("chk_wr_mis", 1'b1, 32'h4, 1'b0, 1'b0, 32'h0, 32'h0);
        step("chk_wr_oor", 1'b1, 32'h4, 1'b0, 1'b0, 32'h0, 32'h0);
        // Write-first collision.
        step("wr_first", 1'b1, 32'h8, 1'b0, 1'b1, 32'h8, 32'h1210000C);
        // Stall holds the response while addresses change.
        step("prog_stall", 1'b0, 32'h0, 1'b0, 1'b1, 32'h10, 32'h08000004);
        step("fetch_stall", 1'b1, 32'h10, 1'b0, 1'b0, 32'h0, 32'h0);
        step("stall1", 1'b1, 32'h0, 1'b1, 1'b0, 32'h0, 32'h0);
        step("stall2", 1'b1, 32'h8, 1'b1, 1'b0, 32'h0, 32'h0);
        step("stall3", 1'b1, 32'h6, 1'b1, 1'b0, 32'h0, 32'h0);
        step("unstall_idle", 1'b0, 32'h8, 1'b0, 1'b0, 32'h0, 32'h0);
        step("idle2", 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);

`ifdef IMEM_PARITY_EN
        step("par_prog", 1'b0, 32'h0, 1'b0, 1'b1, 32'h4, 32'h000000A5);
        dut.u_ram.r_mem[1] = dut.u_ram.r_mem[1] ^ 33'h1;
        @(negedge clk);
        idle_inputs();
        fetch_req  = 1'b1;
        fetch_addr = 32'h4;
        @(posedge clk);
        #1;
        check("parity.instr", fetch_instr, 32'h0);
        check("parity.fault", 32'(fetch_fault), 32'd3);
        m_valid = 1'b1;
        m_instr = 32'h0;
        m_fault = 2'd3;
        step("par_fix", 1'b0, 32'h0, 1'b0, 1'b1, 32'h4, 32'h000000A5);
`endif

        // Randomized traffic, biased towards a few words so reads hit writes.
        for (int i = 0; i < 400; i++) begin
            r = $urandom_range(0, 9);
            if (r < 6)      fa = 32'($urandom_range(0, 15)) * 4;
            else if (r < 7) fa = 32'($urandom_range(0, 255)) * 4;
            else if (r < 8) fa = 32'($urandom_range(0, 1023)) | 32'h1;
            else            fa = 32'h400 + 32'($urandom_range(0, 4095)) * 4;
            r  = $urandom_range(0, 9);
            pa = (r < 8) ? 32'($urandom_range(0, 15)) * 4 : 32'($urandom_range(0, 2047));
            pd = $urandom;
            req = ($urandom_range(0, 3) != 0);
            st  = ($urandom_range(0, 4) == 0);
            we  = ($urandom_range(0, 1) == 1);
            step("rand", req, fa, st, we, pa, pd);
        end

        // Reset while READY with a response outstanding.
        step("pre_rst", 1'b1, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
        hold_reset("rst_ready");
        // Abort CLEAR midway: the full clear must run again from index 0.
        @(negedge clk);
        rst_n = 1'b1;
        repeat (50) @(negedge clk);
        check("mid_clear.ready", 32'(fetch_ready), 32'd0);
        hold_reset("rst_clear");
        release_and_count("clear_len1");
        step("post_fetch8", 1'b1, 32'h8, 1'b0, 1'b0, 32'h0, 32'h0);
        step("post_fetch0", 1'b1, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
